// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave controller.
package i2c_slave_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    I2C_IDLE      = 4'd0,
    I2C_ADDR      = 4'd1,
    I2C_ADDR_ACK  = 4'd2,
    I2C_PTR       = 4'd3,
    I2C_PTR_ACK   = 4'd4,
    I2C_WDATA     = 4'd5,
    I2C_WDATA_ACK = 4'd6,
    I2C_RDATA     = 4'd7,
    I2C_RDATA_ACK = 4'd8
  } i2c_state_t;

  // 2-of-3 majority vote used by the optional glitch filter.
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer, optional 3-sample majority glitch filter and
// bus-event pulse generation (SCL rise/fall, START, STOP).
// Optional feature macro: I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_line_sync
  import i2c_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_lvl;
  logic                   sda_lvl;
  logic                   scl_d_q;
  logic                   sda_d_q;

  // Metastability synchronizer chains for both bus lines.
  // NOTE: these flops reset to 1 (idle bus level) so leaving reset on a quiet
  // bus never looks like an SDA/SCL edge, START or STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q;
  logic [2:0] sda_hist_q;
  logic       scl_filt_q;
  logic       sda_filt_q;

  // Three-sample history plus registered majority: single-clock pulses vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[SYNC_STAGES-1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[SYNC_STAGES-1]};
      scl_filt_q <= maj3(scl_hist_q);
      sda_filt_q <= maj3(sda_hist_q);
    end
  end

  assign scl_lvl = scl_filt_q;
  assign sda_lvl = sda_filt_q;
`else
  assign scl_lvl = scl_sync_q[SYNC_STAGES-1];
  assign sda_lvl = sda_sync_q[SYNC_STAGES-1];
`endif

  // Previous-level registers used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d_q <= 1'b1;
      sda_d_q <= 1'b1;
    end else begin
      scl_d_q <= scl_lvl;
      sda_d_q <= sda_lvl;
    end
  end

  assign sda       = sda_lvl;
  assign scl_rise  =  scl_lvl & ~scl_d_q;
  assign scl_fall  = ~scl_lvl &  scl_d_q;
  // SCL must be high in both samples so a START/STOP never coincides with an SCL edge.
  assign start_det =  scl_lvl &  scl_d_q & ~sda_lvl &  sda_d_q;
  assign stop_det  =  scl_lvl &  scl_d_q &  sda_lvl & ~sda_d_q;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave controller: address match, register-pointer write, data writes
// and auto-incrementing reads with a one-cycle strobe register-file interface.
// Optional feature macro (handled in i2c_line_sync): I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_ctrl
  import i2c_slave_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h29,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [I2C_DATA_W-1:0] reg_addr,
  output logic [I2C_DATA_W-1:0] reg_wdata,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [I2C_DATA_W-1:0] reg_rdata,
  output logic                  busy
);

  localparam logic [3:0] ST_IDLE      = I2C_IDLE;
  localparam logic [3:0] ST_ADDR      = I2C_ADDR;
  localparam logic [3:0] ST_ADDR_ACK  = I2C_ADDR_ACK;
  localparam logic [3:0] ST_PTR       = I2C_PTR;
  localparam logic [3:0] ST_PTR_ACK   = I2C_PTR_ACK;
  localparam logic [3:0] ST_WDATA     = I2C_WDATA;
  localparam logic [3:0] ST_WDATA_ACK = I2C_WDATA_ACK;
  localparam logic [3:0] ST_RDATA     = I2C_RDATA;
  localparam logic [3:0] ST_RDATA_ACK = I2C_RDATA_ACK;

  logic                  sda_lvl;
  logic                  scl_rise;
  logic                  scl_fall;
  logic                  start_det;
  logic                  stop_det;

  logic [3:0]            state_q;
  logic [2:0]            bit_cnt_q;
  logic                  byte_done_q;
  logic [I2C_DATA_W-1:0] shift_q;
  logic                  rw_q;
  logic                  mack_q;
  logic                  sda_oe_q;
  logic [I2C_DATA_W-1:0] reg_addr_q;
  logic [I2C_DATA_W-1:0] reg_wdata_q;
  logic                  reg_wr_q;
  logic                  busy_q;
  logic                  rd_load;
  logic [I2C_DATA_W-1:0] rx_byte;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda       (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign rx_byte = {shift_q[I2C_DATA_W-2:0], sda_lvl};

  // Read strobe: fires on the SCL fall that ends ADDR_ACK (read) or an ACKed read byte.
  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    rd_load = 1'b0;
    if (scl_fall) begin
      if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) rd_load = 1'b1;
      if (state_q == ST_RDATA_ACK && mack_q)             rd_load = 1'b1;
    end
  end

  // Protocol FSM, shift register, register pointer and strobes.
  // NOTE: all state here uses non-blocking assignments so every flop sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      shift_q     <= '0;
      rw_q        <= I2C_RW_WRITE;
      mack_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      reg_wr_q <= 1'b0;
      if (stop_det) begin
        state_q     <= ST_IDLE;
        sda_oe_q    <= 1'b0;
        busy_q      <= 1'b0;
        byte_done_q <= 1'b0;
      end else if (start_det) begin
        state_q     <= ST_ADDR;
        bit_cnt_q   <= '0;
        byte_done_q <= 1'b0;
        sda_oe_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise && !byte_done_q) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                byte_done_q <= 1'b1;
                if (state_q == ST_ADDR) begin
                  if (rx_byte[I2C_DATA_W-1:1] == SLAVE_ADDR) begin
                    rw_q   <= rx_byte[0];
                    busy_q <= 1'b1;
                  end else begin
                    // Not our address: go deaf until the next START.
                    state_q     <= ST_IDLE;
                    byte_done_q <= 1'b0;
                    busy_q      <= 1'b0;
                  end
                end else if (state_q == ST_PTR) begin
                  reg_addr_q <= rx_byte;
                end else begin
                  reg_wdata_q <= rx_byte;
                  reg_wr_q    <= 1'b1;
                end
              end
            end else if (scl_fall && byte_done_q) begin
              // Byte complete and SCL now low: drive ACK for the ninth clock.
              byte_done_q <= 1'b0;
              sda_oe_q    <= 1'b1;
              state_q     <= (state_q == ST_ADDR) ? ST_ADDR_ACK :
                             (state_q == ST_PTR)  ? ST_PTR_ACK  : ST_WDATA_ACK;
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= '0;
              if (rd_load) begin
                shift_q  <= reg_rdata;
                sda_oe_q <= ~reg_rdata[I2C_DATA_W-1];
                state_q  <= ST_RDATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_PTR;
              end
            end
          end

          ST_PTR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= '0;
              sda_oe_q  <= 1'b0;
              state_q   <= ST_WDATA;
            end
          end

          ST_WDATA_ACK: begin
            if (scl_fall) begin
              bit_cnt_q  <= '0;
              sda_oe_q   <= 1'b0;
              reg_addr_q <= reg_addr_q + 8'd1;
              state_q    <= ST_WDATA;
            end
          end

          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
            end else if (scl_fall) begin
              if (byte_done_q) begin
                // Release SDA so the master can drive its ACK/NACK.
                byte_done_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                state_q     <= ST_RDATA_ACK;
              end else begin
                shift_q  <= {shift_q[I2C_DATA_W-2:0], 1'b0};
                sda_oe_q <= ~shift_q[I2C_DATA_W-2];
              end
            end
          end

          ST_RDATA_ACK: begin
            if (scl_rise) begin
              mack_q <= ~sda_lvl;
              // Advance the pointer before the next read strobe on the following fall.
              if (!sda_lvl) reg_addr_q <= reg_addr_q + 8'd1;
            end else if (scl_fall) begin
              bit_cnt_q <= '0;
              if (rd_load) begin
                shift_q  <= reg_rdata;
                sda_oe_q <= ~reg_rdata[I2C_DATA_W-1];
                state_q  <= ST_RDATA;
              end else begin
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
                state_q  <= ST_IDLE;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = rd_load;
  assign busy      = busy_q;

endmodule
